// File: rtl/ga_generation_ctrl_if.sv
// Handshake bundle between the GA generation scheduler (master) and the
// stage datapaths plus run control (slave).
interface ga_generation_ctrl_if #(
    parameter int FIT_W = 12
);
    logic             run;
    logic             abort;
    logic [FIT_W-1:0] fit_target;
    logic [FIT_W-1:0] best_fit;
    logic             sel_start;
    logic             xo_start;
    logic             mut_start;
    logic             sel_done;
    logic             xo_done;
    logic             mut_done;
    logic [31:0]      prg_seed;
    logic [15:0]      gen_count;
    logic             busy;
    logic             run_done;
    logic             err;
    logic [1:0]       err_stage;

    modport master (
        input  run, abort, fit_target, best_fit, sel_done, xo_done, mut_done,
        output sel_start, xo_start, mut_start, prg_seed, gen_count,
               busy, run_done, err, err_stage
    );

    modport slave (
        output run, abort, fit_target, best_fit, sel_done, xo_done, mut_done,
        input  sel_start, xo_start, mut_start, prg_seed, gen_count,
               busy, run_done, err, err_stage
    );
endinterface

// File: rtl/ga_generation_ctrl.sv
// Generation scheduler for one GA run: sequences selection, crossover and
// mutation per generation with fresh LFSR seeds and a per-stage watchdog.
module ga_generation_ctrl #(
    parameter int          MAX_GEN   = 1000,
    parameter int          TIMEOUT   = 4096,
    parameter int          FIT_W     = 12,
    parameter logic [31:0] SEED_INIT = 32'hACE1_2468
) (
    input logic                  clk,
    input logic                  rst_n,
    ga_generation_ctrl_if.master bus
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SEL_GO  = 4'd1;
    localparam logic [3:0] SEL_GAP = 4'd2;
    localparam logic [3:0] XO_GO   = 4'd3;
    localparam logic [3:0] XO_GAP  = 4'd4;
    localparam logic [3:0] MUT_GO  = 4'd5;
    localparam logic [3:0] MUT_GAP = 4'd6;
    localparam logic [3:0] CHECK   = 4'd7;
    localparam logic [3:0] DONE    = 4'd8;
    localparam logic [3:0] ERR     = 4'd9;

    localparam int               WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [15:0]      GEN_LIMIT  = 16'(MAX_GEN);
    // An all-zero Galois LFSR would lock up, so zero is replaced by one.
    localparam logic [31:0]      SEED_RESET = (SEED_INIT == 32'd0) ? 32'd1 : SEED_INIT;

    logic [3:0]       state_q, state_d;
    logic [15:0]      genCount_q, genCount_d;
    logic [FIT_W-1:0] bestFit_q, bestFit_d;
    logic [FIT_W-1:0] fitTarget_q, fitTarget_d;
    logic [31:0]      seed_q, seed_d;
    logic [WD_W-1:0]  wdCount_q, wdCount_d;
    logic [1:0]       errStage_q, errStage_d;
    logic             enterGo;
    logic             wdExpired;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        lfsrStep = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    assign wdExpired = (wdCount_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        genCount_d  = genCount_q;
        bestFit_d   = bestFit_q;
        fitTarget_d = fitTarget_q;
        seed_d      = seed_q;
        wdCount_d   = wdCount_q;
        errStage_d  = errStage_q;
        enterGo     = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.run) begin
                    fitTarget_d = bus.fit_target;
                    genCount_d  = 16'd0;
                    errStage_d  = 2'd0;
                    state_d     = SEL_GO;
                    enterGo     = 1'b1;
                end
            end
            SEL_GO: begin
                if (bus.sel_done) begin
                    bestFit_d = bus.best_fit;
                    state_d   = SEL_GAP;
                end else if (wdExpired) begin
                    state_d    = ERR;
                    errStage_d = 2'd1;
                end else begin
                    wdCount_d = wdCount_q + 1'b1;
                end
            end
            SEL_GAP: begin
                state_d = XO_GO;
                enterGo = 1'b1;
            end
            XO_GO: begin
                if (bus.xo_done) begin
                    state_d = XO_GAP;
                end else if (wdExpired) begin
                    state_d    = ERR;
                    errStage_d = 2'd2;
                end else begin
                    wdCount_d = wdCount_q + 1'b1;
                end
            end
            XO_GAP: begin
                state_d = MUT_GO;
                enterGo = 1'b1;
            end
            MUT_GO: begin
                if (bus.mut_done) begin
                    genCount_d = (genCount_q == 16'hFFFF) ? 16'hFFFF : genCount_q + 16'd1;
                    state_d    = MUT_GAP;
                end else if (wdExpired) begin
                    state_d    = ERR;
                    errStage_d = 2'd3;
                end else begin
                    wdCount_d = wdCount_q + 1'b1;
                end
            end
            MUT_GAP: state_d = CHECK;
            CHECK: begin
                if (bestFit_q <= fitTarget_q) begin
                    state_d = DONE;
                end else if (genCount_q == GEN_LIMIT) begin
                    state_d = DONE;
                end else begin
                    state_d = SEL_GO;
                    enterGo = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enterGo) begin
            seed_d    = lfsrStep(seed_q);
            wdCount_d = '0;
        end

        // Abort overrides whatever the state machine decided this cycle.
        if (bus.abort) begin
            state_d     = IDLE;
            genCount_d  = genCount_q;
            bestFit_d   = bestFit_q;
            fitTarget_d = fitTarget_q;
            seed_d      = seed_q;
            wdCount_d   = '0;
            errStage_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            genCount_q  <= 16'd0;
            bestFit_q   <= '0;
            fitTarget_q <= '0;
            seed_q      <= SEED_RESET;
            wdCount_q   <= '0;
            errStage_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            genCount_q  <= genCount_d;
            bestFit_q   <= bestFit_d;
            fitTarget_q <= fitTarget_d;
            seed_q      <= seed_d;
            wdCount_q   <= wdCount_d;
            errStage_q  <= errStage_d;
        end
    end

    assign bus.sel_start = (state_q == SEL_GO);
    assign bus.xo_start  = (state_q == XO_GO);
    assign bus.mut_start = (state_q == MUT_GO);
    assign bus.prg_seed  = seed_q;
    assign bus.gen_count = genCount_q;
    assign bus.busy      = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign bus.run_done  = (state_q == DONE);
    assign bus.err       = (state_q == ERR);
    assign bus.err_stage = errStage_q;
endmodule

// File: tb/tb_ga_generation_ctrl.sv
// Directed and randomized bench for ga_generation_ctrl; expected run lengths
// and seeds come from a run-level model of the GA schedule.
module tb_ga_generation_ctrl;
    localparam int          MAX_GEN   = 3;
    localparam int          TIMEOUT   = 16;
    localparam int          FIT_W     = 12;
    localparam logic [31:0] SEED_INIT = 32'hACE1_2468;

    logic        clk;
    logic        rst_n;
    int          testsRun   = 0;
    int          failCount  = 0;
    int          startRises = 0;
    logic [2:0]  prevStarts = 3'b000;
    logic [31:0] seedModel;

    ga_generation_ctrl_if #(.FIT_W(FIT_W)) bus ();

    ga_generation_ctrl #(
        .MAX_GEN  (MAX_GEN),
        .TIMEOUT  (TIMEOUT),
        .FIT_W    (FIT_W),
        .SEED_INIT(SEED_INIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] starts();
        starts = {bus.sel_start, bus.xo_start, bus.mut_start};
    endfunction

    // Independent count of start launches, for pulse-count checks.
    always @(negedge clk) begin
        startRises = startRises + $countones(starts() & ~prevStarts);
        prevStarts = starts();
    end

    // Polynomial x^32 + x^22 + x^2 + x + 1, shifted toward bit 0.
    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        lfsrNext = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [FIT_W-1:0] target);
        bus.fit_target = target;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        checkOutput("run_busy", 32'(bus.busy), 32'd1);
        checkOutput("run_clears_gen", 32'(bus.gen_count), 32'd0);
        checkOutput("run_clears_err", 32'(bus.err), 32'd0);
    endtask

    task automatic setDone(input int stage, input logic val);
        case (stage)
            1:       bus.sel_done = val;
            2:       bus.xo_done  = val;
            default: bus.mut_done = val;
        endcase
    endtask

    task automatic waitStart(input int stage, output bit found);
        logic [2:0] want;
        want  = 3'b100 >> (stage - 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (starts() != 3'b000) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("start_order", 32'(starts()), 32'(want));
        if (found) begin
            seedModel = lfsrNext(seedModel);
            checkOutput("launch_seed", bus.prg_seed, seedModel);
        end
    endtask

    task automatic serviceStage(input int stage, input int latency,
                                input logic [FIT_W-1:0] bf, input bit holdDone);
        bit         found;
        logic [2:0] want;
        want = 3'b100 >> (stage - 1);
        waitStart(stage, found);
        repeat (latency - 1) @(negedge clk);
        checkOutput("start_held", 32'(starts()), 32'(want));
        checkOutput("seed_stable", bus.prg_seed, seedModel);
        if (stage == 1) bus.best_fit = bf;
        setDone(stage, 1'b1);
        @(negedge clk);
        checkOutput("gap_low", 32'(starts()), 32'd0);
        if (!holdDone) setDone(stage, 1'b0);
        // Scramble best_fit so only the value captured with sel_done matters.
        if (stage == 1) bus.best_fit = FIT_W'($urandom);
    endtask

    task automatic waitDone(input int expGens);
        bit seen     = 1'b0;
        bit selAgain = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.run_done) seen = 1'b1;
            else begin
                if (bus.sel_start) selAgain = 1'b1;
                @(negedge clk);
            end
        end
        checkOutput("run_done", 32'(bus.run_done), 32'd1);
        checkOutput("no_extra_sel", 32'(selAgain), 32'd0);
        checkOutput("gen_count", 32'(bus.gen_count), 32'(expGens));
        checkOutput("done_not_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit               found;
        int               rises0;
        int               n;
        int               expGens;
        logic [FIT_W-1:0] target;
        logic [FIT_W-1:0] fits [MAX_GEN];
        logic [FIT_W-1:0] nomFits [MAX_GEN];

        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.abort = 1'b0;
        bus.fit_target = '0;
        bus.best_fit = '0;
        bus.sel_done = 1'b0;
        bus.xo_done = 1'b0;
        bus.mut_done = 1'b0;
        seedModel = SEED_INIT;

        #23;
        checkOutput("reset_starts", 32'(starts()), 32'd0);
        checkOutput("reset_seed", bus.prg_seed, SEED_INIT);
        checkOutput("reset_gen", 32'(bus.gen_count), 32'd0);
        checkOutput("reset_flags", 32'({bus.busy, bus.run_done, bus.err, bus.err_stage}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal three-generation run, fit target never reached.
        nomFits[0] = 12'h100;
        nomFits[1] = 12'h0FF;
        nomFits[2] = 12'h001;
        rises0 = startRises;
        applyStimulus(12'h000);
        for (int g = 0; g < MAX_GEN; g++) begin
            serviceStage(1, 5, nomFits[g], 1'b0);
            serviceStage(2, 5, 12'h000, 1'b0);
            serviceStage(3, 5, 12'h000, 1'b0);
        end
        waitDone(MAX_GEN);
        checkOutput("nominal_start_pulses", 32'(startRises - rises0), 32'd9);

        // Early stop after generation 1.
        applyStimulus(12'h020);
        serviceStage(1, 3, 12'h010, 1'b0);
        serviceStage(2, 2, 12'h000, 1'b0);
        serviceStage(3, 4, 12'h000, 1'b0);
        waitDone(1);

        // Randomized runs against the run-length model.
        for (int r = 0; r < 5; r++) begin
            target  = FIT_W'($urandom_range(0, 4095));
            expGens = MAX_GEN;
            for (int g = MAX_GEN - 1; g >= 0; g--) begin
                fits[g] = FIT_W'($urandom_range(0, 4095));
            end
            for (int g = MAX_GEN - 1; g >= 0; g--) begin
                if (fits[g] <= target) expGens = g + 1;
            end
            applyStimulus(target);
            for (int g = 0; g < expGens; g++) begin
                serviceStage(1, $urandom_range(1, 10), fits[g], 1'b0);
                serviceStage(2, $urandom_range(1, 10), 12'h000, 1'b0);
                serviceStage(3, $urandom_range(1, 10), 12'h000, 1'b0);
            end
            waitDone(expGens);
        end

        // Crossover never finishes: watchdog trap.
        applyStimulus(12'h000);
        serviceStage(1, 3, 12'h050, 1'b0);
        waitStart(2, found);
        n = 0;
        while (!bus.err && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_err_stage", 32'(bus.err_stage), 32'd2);
        checkOutput("timeout_starts_low", 32'(starts()), 32'd0);
        checkOutput("timeout_not_busy", 32'(bus.busy), 32'd0);

        // Restart from ERR, then abort during mutation with a coincident done.
        applyStimulus(12'h000);
        checkOutput("run_clears_err_stage", 32'(bus.err_stage), 32'd0);
        serviceStage(1, 2, 12'h080, 1'b0);
        serviceStage(2, 2, 12'h000, 1'b0);
        waitStart(3, found);
        repeat (2) @(negedge clk);
        bus.mut_done = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.mut_done = 1'b0;
        bus.abort = 1'b0;
        checkOutput("abort_not_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_starts_low", 32'(starts()), 32'd0);
        checkOutput("abort_gen_count", 32'(bus.gen_count), 32'd0);
        checkOutput("abort_flags", 32'({bus.run_done, bus.err}), 32'd0);
        @(negedge clk);
        checkOutput("abort_stays_idle", 32'(bus.busy), 32'd0);

        // Stale sel_done held high into XO_GO must not advance crossover.
        applyStimulus(12'hFFF);
        serviceStage(1, 2, 12'h123, 1'b1);
        waitStart(2, found);
        repeat (5) @(negedge clk);
        checkOutput("stale_done_xo_held", 32'(starts()), 32'b010);
        bus.sel_done = 1'b0;
        bus.xo_done = 1'b1;
        @(negedge clk);
        bus.xo_done = 1'b0;
        checkOutput("stale_done_gap", 32'(starts()), 32'd0);
        serviceStage(3, 2, 12'h000, 1'b0);
        waitDone(1);

        // Asynchronous reset in the middle of selection.
        applyStimulus(12'h000);
        waitStart(1, found);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_sel_low", 32'(bus.sel_start), 32'd0);
        checkOutput("async_reset_not_busy", 32'(bus.busy), 32'd0);
        checkOutput("async_reset_seed", bus.prg_seed, SEED_INIT);
        @(negedge clk);
        rst_n = 1'b1;
        seedModel = SEED_INIT;
        @(negedge clk);
        checkOutput("post_reset_idle", 32'({bus.busy, starts()}), 32'd0);
        checkOutput("post_reset_gen", 32'(bus.gen_count), 32'd0);

        // First launch after reset restarts the seed sequence.
        applyStimulus(12'hFFF);
        serviceStage(1, 1, 12'h000, 1'b0);
        serviceStage(2, 1, 12'h000, 1'b0);
        serviceStage(3, 1, 12'h000, 1'b0);
        waitDone(1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/ga_generation_ctrl.md
Name: ga_generation_ctrl

Overview:
- Top-level scheduler for one genetic-algorithm run. Sequences the three population stages in a fixed order, once per generation: selection, crossover, then mutation.
- Supplies a fresh pseudo-random seed to each stage launch.
- Counts generations and stops on a generation limit or a fitness target.
- A per-stage watchdog traps hung stages.

Parameters:
- MAX_GEN, 1000, generation limit; the run ends after this many complete generations.
- TIMEOUT, 4096, maximum cycles a stage may hold start before error.
- FIT_W, 12, width of the fitness/distance value (lower is fitter).
- SEED_INIT, 32'hACE1_2468, LFSR value loaded at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  one-cycle pulse that starts a run; ignored unless state is IDLE, DONE or ERR.
- abort  in  1  synchronous; forces IDLE from any state, dropping all stage starts.
- fit_target  in  FIT_W  stop threshold, sampled on run.
- best_fit  in  FIT_W  best distance of the current population, valid when sel_done=1.
- sel_start / xo_start / mut_start  out  1  level start to each stage.
- sel_done / xo_done / mut_done  in  1  stage completion level.
- prg_seed  out  32  seed presented to the active stage.
- gen_count  out  16  completed generations.
- busy  out  1  high in any state other than IDLE, DONE or ERR.
- run_done  out  1  high in DONE.
- err  out  1  high in ERR.
- err_stage  out  2  stage that timed out: 1=sel, 2=xo, 3=mut, 0=none.

Behaviour:
- Reset values: all outputs 0 except prg_seed=SEED_INIT; state=IDLE; watchdog=0.

States:
- IDLE: on run, latch fit_target, clear gen_count, run_done and err, and go to SEL_GO.
- Stage handshake, identical for S in {SEL, XO, MUT}:
  - S_GO: raise S_start. prg_seed stays stable while start is high. Wait for S_done=1.
  - S_DONE seen: drop S_start next cycle. Go to S_GAP.
  - S_GAP: hold start low for exactly 1 cycle, so every stage launch is a fresh rising edge of start. A done still high from the previous stage is ignored here.
- SEL_GO: when sel_done=1, register best_fit. Then go to XO_GO via the gap.
- XO_GO, then MUT_GO, same handshake.
- After MUT completes:
  - gen_count += 1.
  - Go to CHECK.
- CHECK (1 cycle), decision order:
  - If best_fit_reg <= fit_target_reg, go to DONE.
  - Else if gen_count == MAX_GEN, go to DONE.
  - Else go to SEL_GO.
- DONE: run_done=1, hold until the next run or abort.
- ERR: err=1, all starts low, hold until the next run (which clears err) or abort.

Seed generation:
- 32-bit Galois LFSR, taps 32,22,2,1.
- Steps one position in the cycle each *_GO state is entered, so every launch sees a new seed.
- Never loaded with zero. If SEED_INIT=0, substitute 1.

Watchdog:
- Counter clears on entry to each *_GO state and increments while in *_GO.
- If it reaches TIMEOUT before done, go to ERR and set err_stage.
- Done arriving in the same cycle as the timeout wins; no error.

Other rules:
- gen_count saturates at 16'hFFFF. With MAX_GEN <= 65535 it never reaches saturation.
- abort has priority over every transition, including a simultaneous done or run.
- Asserting rst_n mid-stage drops all starts asynchronously.
- Best fitness is compared unsigned.

Test Plan:
- Nominal run: MAX_GEN=3, fit_target=0, each stage returns done 5 cycles after start → exactly 9 start pulses in order sel,xo,mut ×3. Each start is separated by ≥1 low cycle. gen_count=3, run_done=1.
- Early stop: best_fit=12'h010, fit_target=12'h020 → DONE after generation 1, gen_count=1, no second sel_start.
- Timeout: xo_done never rises, TIMEOUT=16 → err=1 and err_stage=2 exactly 16 cycles after xo_start rose; all starts low.
- Abort during MUT_GO with mut_done pulsed the same cycle → IDLE next cycle, gen_count not incremented, busy=0.
- Seed sequence: check prg_seed on each of the first 4 launches against a software LFSR starting at 32'hACE1_2468. All four values differ and stay stable while start is high.
- Stale done: sel_done left high across the gap into XO_GO, with xo_done low → no advance until xo_done=1.
- Async reset mid-SEL_GO → sel_start=0 immediately, without a clock edge. State is IDLE after release.
